// File: rtl/i2c_pkg.sv
// i2c_pkg: shared command/state encodings and bit-cell constants
// for the byte-level I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    CMD_START   = 3'b000,
    CMD_WR      = 3'b001,
    CMD_RD      = 3'b010,
    CMD_STOP    = 3'b011,
    CMD_RESTART = 3'b100
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START1,
    S_START2,
    S_HOLD,
    S_DATA1,
    S_DATA2,
    S_DATA3,
    S_DATA4,
    S_DATA_END,
    S_RESTART,
    S_STOP1,
    S_STOP2
  } state_e;

  localparam int I2C_BITS = 9;
  localparam int QUARTERS = 4;

  function automatic int byte_clocks(input int d);
    return (I2C_BITS * QUARTERS + 1) * d;
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// i2c_sync2: two-flop synchroniser for an open-drain bus line;
// resets to the released (high) level.
module i2c_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= 1'b1;
      q_o  <= 1'b1;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/i2c_master_core.sv
// i2c_master_core: byte-level I2C master with quarter-bit timing,
// SCL stretching and a bounded stretch timeout.
module i2c_master_core
  import i2c_pkg::*;
#(
  parameter int DVSR_W     = 16,
  parameter int TOUT_W     = 16,
  parameter int STRETCH_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DVSR_W-1:0] dvsr_i,
  input  logic [TOUT_W-1:0] tout_i,
  input  logic [7:0]        din_i,
  input  logic [2:0]        cmd_i,
  input  logic              wr_i2c_i,
  inout  wire               scl_io,
  inout  wire               sda_io,
  output logic              ready_o,
  output logic              done_tick_o,
  output logic              ack_o,
  output logic [7:0]        dout_o,
  output logic              tout_o
);

  state_e            state, state_n;
  cmd_e              cmd;
  logic [DVSR_W-1:0] cnt, ld_val;
  logic [TOUT_W-1:0] str_cnt, tout_q;
  logic [3:0]        bit_cnt;
  logic [8:0]        sreg;
  logic              rx_bit, is_rd;
  logic              scl_oe, sda_oe;
  logic              oe_d1, oe_d2;
  logic              scl_s, sda_s;
  logic              accept, q_end, stall;
  logic              tmo, advance, last_bit;
  logic              reload, ld_byte;

  i2c_sync2 u_scl_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (scl_io),
    .q_o   (scl_s)
  );

  i2c_sync2 u_sda_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (sda_io),
    .q_o   (sda_s)
  );

  assign cmd      = cmd_e'(cmd_i);
  assign ready_o  = (state == S_IDLE) || (state == S_HOLD);
  assign accept   = wr_i2c_i && ready_o;
  assign ld_val   = (dvsr_i == '0) ? '0 : dvsr_i - DVSR_W'(1);
  assign q_end    = (cnt == '0);
  assign last_bit = (bit_cnt == 4'(I2C_BITS - 1));
  assign ld_byte  = (state == S_HOLD) && accept &&
                    ((cmd == CMD_WR) || (cmd == CMD_RD));

  // Our own SCL release needs two cycles to reach scl_s; mask it
  // so only a slave holding SCL low counts as stretching.
  assign stall   = (STRETCH_EN != 0) && (state == S_DATA2) &&
                   !scl_s && !oe_d1 && !oe_d2;
  assign tmo     = stall && (tout_q != '0) &&
                   (str_cnt == tout_q - TOUT_W'(1));
  assign advance = q_end && !stall;
  assign reload  = (state_n != state) || stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (accept && cmd == CMD_START) state_n = S_START1;
      S_START1:  if (advance) state_n = S_START2;
      S_START2:  if (advance) state_n = S_HOLD;
      S_HOLD:
        if (accept) begin
          unique case (1'b1)
            cmd == CMD_WR,
            cmd == CMD_RD:      state_n = S_DATA1;
            cmd == CMD_RESTART: state_n = S_RESTART;
            cmd == CMD_STOP:    state_n = S_STOP1;
            default:            ;
          endcase
        end
      S_DATA1:   if (advance) state_n = S_DATA2;
      S_DATA2:
        if (tmo)          state_n = S_IDLE;
        else if (advance) state_n = S_DATA3;
      S_DATA3:   if (advance) state_n = S_DATA4;
      S_DATA4:
        if (advance) state_n = last_bit ? S_DATA_END : S_DATA1;
      S_DATA_END: if (advance) state_n = S_HOLD;
      S_RESTART: if (advance) state_n = S_START1;
      S_STOP1:   if (advance) state_n = S_STOP2;
      S_STOP2:   if (advance) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state)
      S_START1, S_STOP1: sda_oe = 1'b1;
      S_START2, S_HOLD, S_DATA_END: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
      end
      S_DATA1, S_DATA4: begin
        scl_oe = 1'b1;
        sda_oe = !sreg[8];
      end
      S_DATA2, S_DATA3: sda_oe = !sreg[8];
      default: ;
    endcase
  end

  assign scl_io = scl_oe ? 1'b0 : 1'bz;
  assign sda_io = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt     <= '0;
      tout_q  <= '0;
      str_cnt <= '0;
      oe_d1   <= 1'b0;
      oe_d2   <= 1'b0;
    end else begin
      if (reload) begin
        cnt    <= ld_val;
        tout_q <= tout_i;
      end else if (!q_end) begin
        cnt <= cnt - DVSR_W'(1);
      end
      if (state_n != state) str_cnt <= '0;
      else if (stall)       str_cnt <= str_cnt + TOUT_W'(1);
      oe_d1 <= scl_oe;
      oe_d2 <= oe_d1;
    end
  end

  // Shift happens at the end of DATA4 so SDA never moves while SCL is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg    <= '1;
      rx_bit  <= 1'b1;
      is_rd   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (ld_byte) begin
        sreg    <= (cmd == CMD_WR) ? {din_i, 1'b1} : {8'hFF, din_i[0]};
        is_rd   <= (cmd == CMD_RD);
        bit_cnt <= '0;
      end else if (state == S_DATA4 && advance) begin
        sreg    <= {sreg[7:0], rx_bit};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (state == S_DATA3 && advance) rx_bit <= sda_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_tick_o <= 1'b0;
      ack_o       <= 1'b1;
      dout_o      <= '0;
      tout_o      <= 1'b0;
    end else begin
      done_tick_o <= (state == S_DATA_END) && advance;
      if (state == S_DATA_END && advance) begin
        if (is_rd) dout_o <= sreg[8:1];
        else       ack_o  <= sreg[0];
      end
      if (tmo)
        tout_o <= 1'b1;
      else if (state == S_IDLE && accept && cmd == CMD_START)
        tout_o <= 1'b0;
    end
  end

endmodule

// File: doc/i2c_master_core.md
# i2c_master_core

Byte-level I2C bus master driven by the same command/handshake signals the I2C UVC exercises (din/cmd/wr_i2c in; ready/done_tick/ack/dout out), generalised over divider width, with SCL clock-stretching support and a bounded stretch timeout. It sits between a register-mapped host and the open-drain SCL/SDA pads. Lines are only ever driven low or released; pull-ups live outside the block.

## Interface
- `DVSR_W`, 16: width of the quarter-bit divider `dvsr_i`.
- `TOUT_W`, 16: width of the stretch-timeout limit `tout_i`.
- `STRETCH_EN`, 1: 1 = honour slave clock stretching; 0 = free-running SCL.

Ports:
- `clk_i` in 1: system clock; single clock domain.
- `rst_ni` in 1: asynchronous, active-low reset.
- `dvsr_i` in `DVSR_W`: clocks per quarter SCL period; 0 is treated as 1.
- `tout_i` in `TOUT_W`: maximum stretch cycles; 0 disables the timeout.
- `din_i` in 8: write byte for WR; bit 0 is the master ACK bit for RD (0 = ACK, 1 = NACK).
- `cmd_i` in 3: START=000, WR=001, RD=010, STOP=011, RESTART=100; other codes are ignored.
- `wr_i2c_i` in 1: command strobe; accepted only while `ready_o` = 1.
- `scl_io` inout 1: open-drain SCL (drives 0 or z).
- `sda_io` inout 1: open-drain SDA (drives 0 or z).
- `ready_o` out 1: idle or holding, able to accept a command.
- `done_tick_o` out 1: one-cycle pulse at the end of a WR or RD byte.
- `ack_o` out 1: ACK bit sampled from the slave after WR (0 = ACK).
- `dout_o` out 8: byte received by RD.
- `tout_o` out 1: sticky timeout flag; cleared by the next accepted START.

## Operation
- Reset values: `ready_o`=1, `done_tick_o`=0, `ack_o`=1, `dout_o`=0, `tout_o`=0, SCL and SDA released, state IDLE.
- FSM states: IDLE, START1, START2, HOLD, DATA1, DATA2, DATA3, DATA4, DATA_END, RESTART, STOP1, STOP2.
- Each state other than IDLE and HOLD lasts one quarter period, i.e. `max(dvsr_i,1)` clocks, counted by a `DVSR_W`-bit phase counter that reloads on every state change.
- IDLE (SCL=z, SDA=z): only START is accepted. START -> START1 (SDA=0, SCL=z) -> START2 (SDA=0, SCL=0) -> HOLD.
- HOLD (SCL=0, SDA held):
  - WR/RD: load shift register with {din_i, 1'b1} for WR or {8'hFF, din_i[0]} for RD, then go to DATA1.
  - RESTART: RESTART (SDA=z, SCL=z), then START1.
  - STOP: STOP1 (SDA=0, SCL=z), then STOP2 (SDA=z, SCL=z), then IDLE.
  - START while in HOLD is ignored.
- Bit cell of 9 bits (8 data + ACK), MSB first:
  - DATA1: SCL=0, SDA=bit.
  - DATA2: SCL released.
  - DATA3: SCL=z; sample SDA at the last cycle of DATA3.
  - DATA4: SCL=0.
  - After the 9th bit: DATA_END (SCL=0, one quarter), then HOLD with `done_tick_o` pulsed.
- The WR ACK bit and the RD data bits are driven z and sampled. After RD, `dout_o` holds the 8 received bits. After WR, `ack_o` holds the 9th sampled bit.
- Clock stretching (`STRETCH_EN`=1):
  - In DATA2, the phase counter is frozen while synchronised SCL = 0.
  - In parallel, a `TOUT_W` stretch counter increments.
- Timeout: if the stretch counter reaches `tout_i` (nonzero), the transfer aborts:
  - SCL and SDA are released and the FSM goes to IDLE.
  - `tout_o` is set to 1.
  - No `done_tick_o` is issued, and `dout_o`/`ack_o` are unchanged.
- Inputs `scl_io` and `sda_io` pass through 2-FF synchronisers; all sampling uses the synchronised values.

## Timing
- `ready_o` is combinational: 1 exactly in IDLE and HOLD.
- An accepted command leaves IDLE/HOLD on the next clock edge, so `ready_o` falls one cycle after the strobe.
- Byte latency without stretching: 36·D + D clocks (9 bits × 4 quarters plus DATA_END), where D = max(dvsr_i,1).
- `done_tick_o` is asserted in the first HOLD cycle after DATA_END.
- Stretch adds exactly the number of cycles synchronised SCL is held low during DATA2, plus 2 synchroniser cycles.
- `dvsr_i` and `tout_i` are sampled on every counter reload; changing them mid-byte takes effect at the next quarter.
- `wr_i2c_i` while `ready_o`=0 is dropped with no side effect.
- `rst_ni` low mid-transfer releases both lines immediately (asynchronously) and restores all reset values.

## Structure
- Package `i2c_pkg`:
  - `cmd_e` enum with the 3-bit codes above.
  - `state_e` FSM enum.
  - Constants `I2C_BITS` = 9 and `QUARTERS` = 4.
- Sub-module `i2c_sync2`: 2-FF synchroniser on the async reset, instantiated for SCL and SDA.
- Everything else is a single FSM with phase, bit and stretch counters in `i2c_master_core`.

## Test plan
- D=4: START, WR 8'hA5 with slave ACK, STOP -> SDA bits 1,0,1,0,0,1,0,1; `ack_o`=0; `done_tick_o` 148 clocks after the WR strobe.
- D=4: START, RD with din_i[0]=1 while slave drives 8'h3C -> `dout_o`=8'h3C; master leaves SDA released on the 9th bit (NACK).
- Stretching: slave holds SCL low 50 clocks in bit 3 with `tout_i`=100 -> byte completes with latency extended by 52; `tout_o`=0.
- Timeout: `tout_i`=20, SCL held low indefinitely -> lines released, state IDLE, `tout_o`=1, no `done_tick_o`; next START clears `tout_o`.
- Reject rules: WR in IDLE, START in HOLD, and any strobe while busy -> no bus activity and no state change.
- Reset mid-byte: `rst_ni` low during DATA3 -> SCL/SDA at z the same cycle, `ready_o`=1, `dout_o`=0.
